// File: rtl/bcd_to_bin_seq_pkg.sv
// -----------------------------------------------------------------------------
// bcd_to_bin_seq_pkg
//   Shared definitions for the sequential BCD-to-binary converter:
//   state encoding, BCD digit constants and the per-digit helpers used by the
//   reverse double-dabble datapath.
// -----------------------------------------------------------------------------
package bcd_to_bin_seq_pkg;

    // State encoding
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = S_IDLE,
        ST_SHIFT = S_SHIFT,
        ST_DONE  = S_DONE
    } state_t;

    // BCD digit constants
    localparam logic [3:0] BCD_MAX    = 4'd9;
    localparam logic [3:0] ADJ_THRESH = 4'd8;
    localparam logic [3:0] ADJ_SUB    = 4'd3;

    // A packed nibble is not a decimal digit when it exceeds 9.
    function automatic logic digit_invalid(input logic [3:0] d);
        return (d > BCD_MAX);
    endfunction

    // Reverse double-dabble correction: after a right shift a digit that
    // received a carried-in weight of 8 really represents 5, so remove 3.
    function automatic logic [3:0] digit_adjust(input logic [3:0] d);
        logic [3:0] r;
        if (d >= ADJ_THRESH) begin
            r = d - ADJ_SUB;
        end else begin
            r = d;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_to_bin_seq_digit_adj.sv
// -----------------------------------------------------------------------------
// bcd_digit_adj
//   Combinational correction of one BCD digit after a right shift:
//   dout = (din >= 8) ? din - 3 : din.
// Ports
//   din   in  4   shifted BCD digit
//   dout  out 4   corrected BCD digit
// -----------------------------------------------------------------------------
module bcd_digit_adj
    import bcd_to_bin_seq_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // Apply the subtract-3 correction to a single digit
    always_comb begin
        dout = digit_adjust(din);
    end

endmodule

// File: rtl/bcd_to_bin_seq.sv
// -----------------------------------------------------------------------------
// bcd_to_bin_seq
//   Sequential BCD-to-binary converter (reverse double-dabble, one bit per
//   clock) with a start/done handshake.
// Parameters
//   DIGITS  number of packed BCD input digits (>=1)
//   BIN_W   binary result width; 2**BIN_W must exceed 10**DIGITS-1
// Ports
//   clk      in   1          rising-edge clock
//   rst_n    in   1          asynchronous active-low reset
//   start    in   1          conversion request, sampled only in IDLE
//   bcd_in   in   4*DIGITS   packed BCD, digit0 = bcd_in[3:0]
//   busy     out  1          conversion in progress
//   done     out  1          one-cycle pulse, bin_out/err valid
//   bin_out  out  BIN_W      binary result, held between conversions
//   err      out  1          a captured digit was > 9 (bin_out forced to 0)
// -----------------------------------------------------------------------------
module bcd_to_bin_seq
    import bcd_to_bin_seq_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int BIN_W  = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  err
);

    localparam int BCD_W  = 4 * DIGITS;
    localparam int SREG_W = BCD_W + BIN_W;
    localparam int CNT_W  = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

    state_t              state_r,    state_nxt_s;
    logic [SREG_W-1:0]   sreg_r,     sreg_nxt_s;
    logic [CNT_W-1:0]    cnt_r,      cnt_nxt_s;
    logic                err_pend_r, err_pend_nxt_s;

    logic                busy_r;
    logic                done_r;
    logic                err_r;
    logic [BIN_W-1:0]    bin_out_r;

    logic [SREG_W-1:0]   shifted_s;
    logic [BCD_W-1:0]    adj_field_s;
    logic                invalid_s;

    assign shifted_s = sreg_r >> 1;

    // One corrector per BCD field of the shifted register
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (shifted_s[BIN_W + 4*g +: 4]),
            .dout (adj_field_s[4*g +: 4])
        );
    end

    // Flag any non-decimal digit on the input bus
    always_comb begin
        invalid_s = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (digit_invalid(bcd_in[4*i +: 4])) begin
                invalid_s = 1'b1;
            end else begin
                invalid_s = invalid_s;
            end
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_nxt_s    = state_r;
        sreg_nxt_s     = sreg_r;
        cnt_nxt_s      = cnt_r;
        err_pend_nxt_s = err_pend_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (invalid_s) begin
                        // Bad digit: skip the shifting and report at once
                        sreg_nxt_s     = {SREG_W{1'b0}};
                        err_pend_nxt_s = 1'b1;
                        state_nxt_s    = ST_DONE;
                    end else begin
                        sreg_nxt_s     = {bcd_in, {BIN_W{1'b0}}};
                        cnt_nxt_s      = {CNT_W{1'b0}};
                        err_pend_nxt_s = 1'b0;
                        state_nxt_s    = ST_SHIFT;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                sreg_nxt_s = {adj_field_s, shifted_s[BIN_W-1:0]};
                cnt_nxt_s  = cnt_r + CNT_W'(1);
                if (cnt_r == CNT_LAST) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            sreg_r     <= {SREG_W{1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
            err_pend_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            sreg_r     <= sreg_nxt_s;
            cnt_r      <= cnt_nxt_s;
            err_pend_r <= err_pend_nxt_s;
        end
    end

    // Registered handshake and result outputs; results update only when
    // leaving DONE so they stay stable between conversions
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
            bin_out_r <= {BIN_W{1'b0}};
        end else begin
            busy_r <= (state_r == ST_SHIFT);
            done_r <= (state_r == ST_DONE);
            if (state_r == ST_DONE) begin
                err_r <= err_pend_r;
                if (err_pend_r) begin
                    bin_out_r <= {BIN_W{1'b0}};
                end else begin
                    bin_out_r <= sreg_r[BIN_W-1:0];
                end
            end else begin
                err_r     <= err_r;
                bin_out_r <= bin_out_r;
            end
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign err     = err_r;
    assign bin_out = bin_out_r;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
module tb_bcd_to_bin_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  bcd_in;
    logic        busy, done, err;
    logic [6:0]  bin_out;

    logic        start3;
    logic [11:0] bcd3;
    logic        busy3, done3, err3;
    logic [9:0]  bin3;

    int checks = 0;
    int passed = 0;

    bcd_to_bin_seq #(.DIGITS(2), .BIN_W(7)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bcd_in(bcd_in),
        .busy(busy), .done(done), .bin_out(bin_out), .err(err)
    );

    bcd_to_bin_seq #(.DIGITS(3), .BIN_W(10)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .bcd_in(bcd3),
        .busy(busy3), .done(done3), .bin_out(bin3), .err(err3)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive one conversion on the 2-digit instance; returns observations only.
    task automatic run2(input logic [7:0] v, input int pre_idle, output int lat,
                        output int bcnt, output logic [6:0] b, output logic e,
                        output logic dn_after);
        for (int k = 0; k < pre_idle; k++) begin
            @(posedge clk); #1;
        end
        bcd_in = v; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; bcd_in = 8'hFF;
        lat = 0; bcnt = 0;
        while (done !== 1'b1 && lat < 40) begin
            bcnt += (busy === 1'b1) ? 1 : 0;
            @(posedge clk); #1;
            lat++;
        end
        b = bin_out; e = err;
        @(posedge clk); #1;
        dn_after = done;
    endtask

    // Drive one conversion on the 3-digit instance.
    task automatic run3(input logic [11:0] v, input int pre_idle, output int lat,
                        output logic [9:0] b, output logic e);
        for (int k = 0; k < pre_idle; k++) begin
            @(posedge clk); #1;
        end
        bcd3 = v; start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0; bcd3 = 12'hFFF;
        lat = 0;
        while (done3 !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        b = bin3; e = err3;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        int dn_seen;
        rst_n = 1'b0; start = 1'b1; bcd_in = 8'h42; start3 = 1'b0; bcd3 = 12'h000;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
        checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else passed++;
        checks++; if (err !== 1'b0) $display("FAIL reset_err: got %b expected 0", err); else passed++;
        checks++; if (bin_out !== 7'd0) $display("FAIL reset_bin: got %0d expected 0", bin_out); else passed++;
        start = 1'b0;
        rst_n = 1'b1;
        dn_seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) dn_seen++;
        end
        checks++; if (dn_seen !== 0) $display("FAIL reset_no_conv: got %0d active cycles expected 0", dn_seen); else passed++;
    endtask

    task automatic test_basic();
        int lat, bcnt; logic [6:0] b; logic e, dn;
        run2(8'h42, 0, lat, bcnt, b, e, dn);
        checks++; if (lat !== 8) $display("FAIL basic_latency: got %0d expected 8", lat); else passed++;
        checks++; if (bcnt !== 7) $display("FAIL basic_busy_cycles: got %0d expected 7", bcnt); else passed++;
        checks++; if (b !== 7'd42) $display("FAIL basic_bin: got %0d expected 42", b); else passed++;
        checks++; if (e !== 1'b0) $display("FAIL basic_err: got %b expected 0", e); else passed++;
        checks++; if (dn !== 1'b0) $display("FAIL basic_done_pulse: got %b expected 0", dn); else passed++;
        checks++; if (dut.sreg_r[14:7] !== 8'h00) $display("FAIL basic_upper_field: got %h expected 00", dut.sreg_r[14:7]); else passed++;
        checks++; if (bin_out !== 7'd42) $display("FAIL basic_bin_hold: got %0d expected 42", bin_out); else passed++;
    endtask

    task automatic test_boundary();
        int lat, bcnt; logic [6:0] b; logic e, dn;
        run2(8'h99, 0, lat, bcnt, b, e, dn);
        checks++; if (b !== 7'd99) $display("FAIL max_bin: got %0d expected 99", b); else passed++;
        checks++; if (e !== 1'b0) $display("FAIL max_err: got %b expected 0", e); else passed++;
        run2(8'h00, 1, lat, bcnt, b, e, dn);
        checks++; if (b !== 7'd0) $display("FAIL zero_bin: got %0d expected 0", b); else passed++;
        checks++; if (lat !== 8) $display("FAIL zero_latency: got %0d expected 8", lat); else passed++;
        checks++; if (e !== 1'b0) $display("FAIL zero_err: got %b expected 0", e); else passed++;
    endtask

    task automatic test_invalid();
        int lat, bcnt; logic [6:0] b; logic e, dn;
        run2(8'h3A, 0, lat, bcnt, b, e, dn);
        checks++; if (lat !== 1) $display("FAIL inv_latency: got %0d expected 1", lat); else passed++;
        checks++; if (e !== 1'b1) $display("FAIL inv_err: got %b expected 1", e); else passed++;
        checks++; if (b !== 7'd0) $display("FAIL inv_bin: got %0d expected 0", b); else passed++;
        checks++; if (bcnt !== 0) $display("FAIL inv_busy: got %0d busy cycles expected 0", bcnt); else passed++;
        checks++; if (err !== 1'b1) $display("FAIL inv_err_hold: got %b expected 1", err); else passed++;
        run2(8'h05, 0, lat, bcnt, b, e, dn);
        checks++; if (e !== 1'b0) $display("FAIL inv_err_clear: got %b expected 0", e); else passed++;
        checks++; if (b !== 7'd5) $display("FAIL inv_next_bin: got %0d expected 5", b); else passed++;
        run2(8'hA0, 0, lat, bcnt, b, e, dn);
        checks++; if (e !== 1'b1) $display("FAIL inv_upper_digit: got %b expected 1", e); else passed++;
    endtask

    task automatic test_start_held();
        int cyc, first_t, second_t, ndone;
        logic [6:0] first_b, second_b;
        first_t = -1; second_t = -1; ndone = 0; first_b = 7'd0; second_b = 7'd0;
        bcd_in = 8'h42; start = 1'b1;
        @(posedge clk); #1;
        bcd_in = 8'h17;
        for (cyc = 0; cyc < 30; cyc++) begin
            if (cyc == 3) bcd_in = 8'h88;
            if (cyc == 6) bcd_in = 8'h17;
            if (done === 1'b1) begin
                ndone++;
                if (ndone == 1) begin first_t = cyc; first_b = bin_out; end
                if (ndone == 2) begin second_t = cyc; second_b = bin_out; start = 1'b0; end
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        checks++; if (first_t !== 8) $display("FAIL held_first_latency: got %0d expected 8", first_t); else passed++;
        checks++; if (first_b !== 7'd42) $display("FAIL held_first_bin: got %0d expected 42", first_b); else passed++;
        checks++; if (second_t - first_t !== 9) $display("FAIL held_interval: got %0d expected 9", second_t - first_t); else passed++;
        checks++; if (second_b !== 7'd17) $display("FAIL held_second_bin: got %0d expected 17", second_b); else passed++;
    endtask

    task automatic test_reset_mid();
        int lat, bcnt, dn_seen; logic [6:0] b; logic e, dn;
        run2(8'h42, 0, lat, bcnt, b, e, dn);
        bcd_in = 8'h57; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        checks++; if (dut.cnt_r !== 3'd3) $display("FAIL mid_cnt: got %0d expected 3", dut.cnt_r); else passed++;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bin_out !== 7'd0) $display("FAIL mid_rst_bin: got %0d expected 0", bin_out); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL mid_rst_busy: got %b expected 0", busy); else passed++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        dn_seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) dn_seen++;
        end
        checks++; if (dn_seen !== 0) $display("FAIL mid_no_done: got %0d expected 0", dn_seen); else passed++;
        run2(8'h57, 0, lat, bcnt, b, e, dn);
        checks++; if (b !== 7'd57) $display("FAIL mid_restart_bin: got %0d expected 57", b); else passed++;
        checks++; if (lat !== 8) $display("FAIL mid_restart_latency: got %0d expected 8", lat); else passed++;
    endtask

    task automatic test_sweep2();
        int lat, bcnt; logic [6:0] b; logic e, dn; logic [7:0] v;
        for (int i = 0; i < 100; i++) begin
            v = {4'(i / 10), 4'(i % 10)};
            run2(v, $urandom_range(0, 2), lat, bcnt, b, e, dn);
            checks++;
            if (b !== 7'(i) || e !== 1'b0 || lat !== 8)
                $display("FAIL sweep2 %h: got bin=%0d err=%b lat=%0d expected bin=%0d err=0 lat=8", v, b, e, lat, i);
            else passed++;
        end
    endtask

    task automatic test_sweep3();
        int lat; logic [9:0] b; logic e; logic [11:0] v;
        for (int i = 0; i < 1000; i++) begin
            v = {4'(i / 100), 4'((i / 10) % 10), 4'(i % 10)};
            run3(v, $urandom_range(0, 1), lat, b, e);
            checks++;
            if (b !== 10'(i) || e !== 1'b0 || lat !== 11)
                $display("FAIL sweep3 %h: got bin=%0d err=%b lat=%0d expected bin=%0d err=0 lat=11", v, b, e, lat, i);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundary();
        test_invalid();
        test_start_held();
        test_reset_mid();
        test_sweep2();
        test_sweep3();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
